// File: rtl/serial_mmio_fifo.sv
// Memory-mapped serial I/O controller with RX/TX byte FIFOs behind a 3-register window.
// Optional interrupt logic (CTRL register + irq_out port) is enabled by defining SERIAL_MMIO_IRQ_EN.
module serial_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic [31:0] writedata_in,
  input  logic        re_in,
  input  logic        we_in,
  output logic        hit_out,
  output logic [31:0] readdata_out,
  input  logic [7:0]  serial_in,
  input  logic        serial_valid_in,
  output logic        serial_rden_out,
  input  logic        serial_ready_in,
  output logic [7:0]  serial_out,
  output logic        serial_wren_out
`ifdef SERIAL_MMIO_IRQ_EN
  ,
  output logic        irq_out
`endif
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       tx_mem_q [TX_DEPTH];

  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_CW-1:0] rx_count_q, rx_count_d;
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_CW-1:0] tx_count_q, tx_count_d;
  logic             err_q, err_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [1:0]       reg_sel;
  logic             store_en, load_en;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             rx_push, rx_pop, tx_push, tx_pop;
  logic [31:0]      status_word, ctrl_word;
  logic             unused_bits;

  // Bus decode. A simultaneous load and store performs only the store.
  assign hit_out  = (addr_in[31:4] == BASE_ADDR[31:4]) && (addr_in[3:2] != 2'd3);
  assign reg_sel  = addr_in[3:2];
  assign store_en = we_in & hit_out;
  assign load_en  = re_in & hit_out & ~we_in;

  assign rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count_q == '0);
  assign tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count_q == '0);

  // Serial handshakes: a byte moves on a rising edge only in a cycle where the
  // producer has valid data and the consumer has room (rden/wren are the "both
  // sides agree" strobes). Decisions use the pre-edge counts only.
  assign rx_push = serial_valid_in & ~rx_full;
  assign rx_pop  = load_en && (reg_sel == REG_DATA) && !rx_empty;
  assign tx_push = store_en && (reg_sel == REG_DATA) && !tx_full;
  assign tx_pop  = serial_ready_in & ~tx_empty;

  assign serial_rden_out = rx_push;
  assign serial_wren_out = tx_pop;
  assign serial_out      = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
  assign readdata_out    = readdata_q;

  assign status_word = {8'h00, 8'(tx_count_q), 8'(rx_count_q),
                        4'h0, tx_empty, err_q, ~tx_full, ~rx_empty};

`ifdef SERIAL_MMIO_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;

  assign ctrl_word = {30'h0, ctrl_q};
  assign irq_out   = irq_q;

  always_comb begin
    ctrl_d = ctrl_q;
    if (store_en && (reg_sel == REG_CTRL)) ctrl_d = writedata_in[1:0];
    irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end
`else
  assign ctrl_word = 32'h0;
`endif

  assign unused_bits = ^{addr_in[1:0], writedata_in[31:8]};

  always_comb begin
    rx_wr_q_next_defaults: begin
      rx_wr_d    = rx_wr_q;
      rx_rd_d    = rx_rd_q;
      rx_count_d = rx_count_q;
      tx_wr_d    = tx_wr_q;
      tx_rd_d    = tx_rd_q;
      tx_count_d = tx_count_q;
      err_d      = err_q;
      readdata_d = readdata_q;
    end

    if (rx_push) rx_wr_d = rx_wr_q + RX_AW'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + RX_AW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
      2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
      default: rx_count_d = rx_count_q;
    endcase

    if (tx_push) tx_wr_d = tx_wr_q + TX_AW'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + TX_AW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
      2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
      default: tx_count_d = tx_count_q;
    endcase

    // err is sticky: set by overflow/underflow, cleared only by software.
    if (store_en && (reg_sel == REG_STATUS) && writedata_in[2]) err_d = 1'b0;
    if (store_en && (reg_sel == REG_DATA) && tx_full)           err_d = 1'b1;
    if (load_en && (reg_sel == REG_DATA) && rx_empty)           err_d = 1'b1;

    if (load_en) begin
      case (reg_sel)
        REG_DATA:   readdata_d = rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rd_q]};
        REG_STATUS: readdata_d = status_word;
        REG_CTRL:   readdata_d = ctrl_word;
        default:    readdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_count_q <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_count_q <= '0;
      err_q      <= 1'b0;
      readdata_q <= 32'h0;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_count_q <= rx_count_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_count_q <= tx_count_d;
      err_q      <= err_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage carries no reset; the counts alone define which entries are live.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= serial_in;
    if (tx_push) tx_mem_q[tx_wr_q] <= writedata_in[7:0];
  end

endmodule
